// File: rtl/counter_run_controller_if.sv
// Control/status bundle between the sequencing logic (master) and the counter run controller (slave).
interface counter_run_controller_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             reload;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             paused;
  logic             wrap;
  logic             done_valid;
  logic             done_ack;

  modport master (
    output start, stop, pause, reload, limit, done_ack,
    input  count, busy, paused, wrap, done_valid
  );

  modport slave (
    input  start, stop, pause, reload, limit, done_ack,
    output count, busy, paused, wrap, done_valid
  );
endinterface

// File: rtl/counter_run_controller.sv
// Start/stop/pause sequencer for a binary up counter with programmable terminal count,
// one-shot or auto-reload operation and a done valid/ack handshake. Macro PRESCALE_EN adds a tick prescaler.
module counter_run_controller #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_run_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("counter_run_controller: PRESCALE must be in 2..256");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             reload_q, reload_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, paused_q, done_q;
  logic             tick;

`ifdef PRESCALE_EN
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CTR_LAST = CW'(PRESCALE - 1);
  logic [CW-1:0] ctr_q, ctr_d;

  assign tick = (ctr_q == CTR_LAST);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lim_d    = lim_q;
    reload_d = reload_q;
    wrap_d   = 1'b0;
`ifdef PRESCALE_EN
    ctr_d    = ctr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.limit != '0)) begin
          lim_d    = bus.limit;
          reload_d = bus.reload;
          count_d  = '0;
          state_d  = S_RUN;
`ifdef PRESCALE_EN
          ctr_d    = '0;
`endif
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.pause) begin
          state_d = S_PAUSE;
        end else begin
`ifdef PRESCALE_EN
          ctr_d = tick ? '0 : ctr_q + 1'b1;
`endif
          // The count dwells on lim_q for one full tick before reloading or finishing.
          if (tick) begin
            if (count_q == lim_q) begin
              if (reload_q) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end else begin
                state_d = S_HOLD;
              end
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.pause) begin
          state_d = S_RUN;
        end
      end
      S_HOLD: begin
        if (bus.done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      lim_q    <= '0;
      reload_q <= 1'b0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      lim_q    <= lim_d;
      reload_q <= reload_d;
      wrap_q   <= wrap_d;
      busy_q   <= (state_d == S_RUN) || (state_d == S_PAUSE);
      paused_q <= (state_d == S_PAUSE);
      done_q   <= (state_d == S_HOLD);
    end
  end

`ifdef PRESCALE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end
`endif

  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.paused     = paused_q;
  assign bus.wrap       = wrap_q;
  assign bus.done_valid = done_q;

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller; tick period follows PRESCALE_EN.
module tb_counter_run_controller;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
`ifdef PRESCALE_EN
  localparam int T = PRESCALE;
`else
  localparam int T = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  counter_run_controller_if #(.WIDTH(WIDTH)) bus ();

  counter_run_controller #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.reload   = 1'b0;
    bus.limit    = '0;
    bus.done_ack = 1'b0;
    step(2);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_paused", int'(bus.paused), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    chk("rst_done", int'(bus.done_valid), 0);
    rst = 1'b0;
    step(1);

    // One-shot run to 5, then hold the handshake
    bus.limit = 4'd5; bus.reload = 1'b0; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk("os_count", int'(bus.count), k);
      chk("os_busy", int'(bus.busy), 1);
      chk("os_done_early", int'(bus.done_valid), 0);
      step(T);
    end
    chk("os_done", int'(bus.done_valid), 1);
    chk("os_busy_end", int'(bus.busy), 0);
    chk("os_count_end", int'(bus.count), 5);
    for (int k = 0; k < 20; k++) begin
      chk("hold_done", int'(bus.done_valid), 1);
      step(1);
    end
    bus.done_ack = 1'b1; bus.start = 1'b1; bus.stop = 1'b1; bus.pause = 1'b1; bus.limit = 4'd2;
    step(1);
    bus.done_ack = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    chk("ack_done", int'(bus.done_valid), 0);
    chk("ack_busy", int'(bus.busy), 0);
    chk("ack_paused", int'(bus.paused), 0);
    chk("ack_count", int'(bus.count), 5);
    step(2);
    chk("ack_idle_busy", int'(bus.busy), 0);

    // Zero limit start is ignored
    bus.limit = '0; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("lim0_busy", int'(bus.busy), 0);
    chk("lim0_count", int'(bus.count), 5);

    // Auto-reload with limit 3; a mid-run start must not restart
    bus.limit = 4'd3; bus.reload = 1'b1; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      chk("ar_count", int'(bus.count), exp_cnt);
      chk("ar_wrap", int'(bus.wrap), (i > 0 && exp_cnt == 0) ? 1 : 0);
      chk("ar_done", int'(bus.done_valid), 0);
      if (i == 5) begin
        bus.start = 1'b1; bus.limit = 4'd1; bus.reload = 1'b0;
      end
      step(T);
      bus.start = 1'b0;
      exp_cnt = (exp_cnt == 3) ? 0 : exp_cnt + 1;
    end
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    chk("ar_stop_busy", int'(bus.busy), 0);

    // Pause at 2, resume, then stop+pause together at 4
    bus.limit = 4'd5; bus.reload = 1'b0; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(2 * T);
    chk("pz_count_pre", int'(bus.count), 2);
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("pz_paused", int'(bus.paused), 1);
      chk("pz_count", int'(bus.count), 2);
      chk("pz_busy", int'(bus.busy), 1);
      step(1);
    end
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
    chk("pz_resume_paused", int'(bus.paused), 0);
    chk("pz_resume_count", int'(bus.count), 2);
    step(T);
    chk("pz_next_count", int'(bus.count), 3);
    step(T);
    chk("sp_count_pre", int'(bus.count), 4);
    bus.stop = 1'b1; bus.pause = 1'b1;
    step(1);
    bus.stop = 1'b0; bus.pause = 1'b0;
    chk("sp_busy", int'(bus.busy), 0);
    chk("sp_paused", int'(bus.paused), 0);
    chk("sp_count", int'(bus.count), 4);
    chk("sp_done", int'(bus.done_valid), 0);
    step(T);
    chk("sp_count_idle", int'(bus.count), 4);

    // Reset in the middle of a run
    bus.limit = 4'd15; bus.reload = 1'b0; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(7 * T);
    chk("mr_count_pre", int'(bus.count), 7);
    rst = 1'b1;
    step(1);
    chk("mr_count", int'(bus.count), 0);
    chk("mr_busy", int'(bus.busy), 0);
    chk("mr_paused", int'(bus.paused), 0);
    chk("mr_wrap", int'(bus.wrap), 0);
    chk("mr_done", int'(bus.done_valid), 0);
    rst = 1'b0;
    step(T + 1);
    chk("mr_idle_busy", int'(bus.busy), 0);
    chk("mr_idle_count", int'(bus.count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
